// File: rtl/mdl_mode_seq.sv
// Command sequencer between the AXI4-Lite control slave and the Ncc-Sign engine:
// launches KEYGEN/SIGN/VERIFY runs, tracks completion/abort/timeout, keeps sticky status.
module mdl_mode_seq #(
    parameter int unsigned CNT_W   = 32,
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input  logic             iSYS_CLK,
    input  logic             iSYS_RST,
    input  logic [2:0]       iCTL_MODE,
    input  logic             iSTS_CLR,
    output logic             oENG_START,
    output logic [1:0]       oENG_OP,
    input  logic             iENG_DONE,
    input  logic             iENG_FAIL,
    output logic             oENG_ABORT,
    output logic             oSTS_BUSY,
    output logic             oSTS_DONE,
    output logic [3:0]       oSTS_ERR,
    output logic [CNT_W-1:0] oCYC_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_ABORT
    } state_t;

    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam bit               WDOG_EN = (TIMEOUT != '0);

    state_t           state;
    logic             mode_none;
    logic             mode_op;
    logic             mode_abort;
    logic             mode_ill;
    logic             wdog_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       err_set;
    logic             done_set;
    logic             done_clr;
    logic             err_clr;

    always_comb begin
        mode_none  = (iCTL_MODE == 3'b000);
        mode_op    = (iCTL_MODE inside {3'b001, 3'b010, 3'b011});
        mode_abort = (iCTL_MODE == 3'b111);
        mode_ill   = !mode_none && !mode_op && !mode_abort;
        wdog_hit   = WDOG_EN && (oCYC_CNT == TO_CNT);
        cnt_inc    = (oCYC_CNT == '1) ? oCYC_CNT : oCYC_CNT + CNT_W'(1);
    end

    // Sticky-bit set/clear requests; the set term is OR-ed after the clear so set wins.
    always_comb begin
        err_set  = '0;
        done_set = 1'b0;
        done_clr = iSTS_CLR;
        err_clr  = iSTS_CLR;
        case (state)
            ST_IDLE: begin
                if (mode_abort) begin
                    done_clr = 1'b1;
                    err_clr  = 1'b1;
                end
                if (mode_ill) err_set[0] = 1'b1;
                if (mode_op)  done_clr   = 1'b1;
            end
            ST_RUN: begin
                if (!mode_none && !mode_abort) err_set[1] = 1'b1;
                if (!mode_abort) begin
                    if (iENG_DONE) begin
                        if (iENG_FAIL) err_set[3] = 1'b1;
                        else           done_set   = 1'b1;
                    end else if (wdog_hit) begin
                        err_set[2] = 1'b1;
                    end
                end
            end
            default: begin
                if (!mode_none && !mode_abort) err_set[1] = 1'b1;
            end
        endcase
    end

    always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
        if (iSYS_RST) begin
            state      <= ST_IDLE;
            oENG_START <= 1'b0;
            oENG_OP    <= '0;
            oENG_ABORT <= 1'b0;
            oSTS_BUSY  <= 1'b0;
            oSTS_DONE  <= 1'b0;
            oSTS_ERR   <= '0;
            oCYC_CNT   <= '0;
        end else begin
            oENG_START <= 1'b0;
            oENG_ABORT <= 1'b0;
            oSTS_ERR   <= (err_clr ? 4'b0000 : oSTS_ERR) | err_set;
            if (done_set)      oSTS_DONE <= 1'b1;
            else if (done_clr) oSTS_DONE <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (mode_op) begin
                        state      <= ST_LAUNCH;
                        oENG_OP    <= iCTL_MODE[1:0];
                        oCYC_CNT   <= '0;
                        oENG_START <= 1'b1;
                        oSTS_BUSY  <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    oCYC_CNT <= cnt_inc;
                    if (mode_abort) begin
                        state      <= ST_ABORT;
                        oENG_ABORT <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mode_abort) begin
                        oCYC_CNT   <= cnt_inc;
                        state      <= ST_ABORT;
                        oENG_ABORT <= 1'b1;
                    end else if (iENG_DONE) begin
                        oCYC_CNT  <= cnt_inc;
                        state     <= ST_IDLE;
                        oSTS_BUSY <= 1'b0;
                    end else if (wdog_hit) begin
                        // Counter freezes at TIMEOUT so software reads back the exact limit.
                        state      <= ST_ABORT;
                        oENG_ABORT <= 1'b1;
                    end else begin
                        oCYC_CNT <= cnt_inc;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    oSTS_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdl_mode_seq.sv
// Directed self-checking bench for mdl_mode_seq (TIMEOUT=16 instance plus a
// narrow-counter, watchdog-disabled instance for saturation).
module tb_mdl_mode_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic        clr;
    logic        done;
    logic        fail;
    logic        start;
    logic [1:0]  op;
    logic        abrt;
    logic        busy;
    logic        sdone;
    logic [3:0]  err;
    logic [31:0] cnt;

    logic [2:0]  mode2;
    logic        clr2;
    logic        done2;
    logic        fail2;
    logic        s_start;
    logic [1:0]  s_op;
    logic        s_abrt;
    logic        s_busy;
    logic        s_sdone;
    logic [3:0]  s_err;
    logic [2:0]  s_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdl_mode_seq #(.CNT_W(32), .TIMEOUT(32'd16)) u_dut (
        .iSYS_CLK  (clk),
        .iSYS_RST  (rst),
        .iCTL_MODE (mode),
        .iSTS_CLR  (clr),
        .oENG_START(start),
        .oENG_OP   (op),
        .iENG_DONE (done),
        .iENG_FAIL (fail),
        .oENG_ABORT(abrt),
        .oSTS_BUSY (busy),
        .oSTS_DONE (sdone),
        .oSTS_ERR  (err),
        .oCYC_CNT  (cnt)
    );

    mdl_mode_seq #(.CNT_W(3), .TIMEOUT(32'd0)) u_sat (
        .iSYS_CLK  (clk),
        .iSYS_RST  (rst),
        .iCTL_MODE (mode2),
        .iSTS_CLR  (clr2),
        .oENG_START(s_start),
        .oENG_OP   (s_op),
        .iENG_DONE (done2),
        .iENG_FAIL (fail2),
        .oENG_ABORT(s_abrt),
        .oSTS_BUSY (s_busy),
        .oSTS_DONE (s_sdone),
        .oSTS_ERR  (s_err),
        .oCYC_CNT  (s_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; mode = 3'b000; clr = 1'b0; done = 1'b0; fail = 1'b0;
        mode2 = 3'b000; clr2 = 1'b0; done2 = 1'b0; fail2 = 1'b0;
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_abort", {30'd0, start, abrt}, 32'd0);
        chk("rst_done_err", {27'd0, sdone, err}, 32'd0);
        chk("rst_op", {30'd0, op}, 32'd0);
        chk("rst_cnt", cnt, 32'd0);
        rst = 1'b0;
        step();

        // KEYGEN normal run, done 5 cycles after START
        mode = 3'b001; step(); mode = 3'b000;
        chk("kg_start", {31'd0, start}, 32'd1);
        chk("kg_busy", {31'd0, busy}, 32'd1);
        chk("kg_op", {30'd0, op}, 32'd1);
        step();
        chk("kg_start_once", {31'd0, start}, 32'd0);
        step(); step(); step(); step();
        done = 1'b1; step(); done = 1'b0;
        chk("kg_busy_end", {31'd0, busy}, 32'd0);
        chk("kg_done", {31'd0, sdone}, 32'd1);
        chk("kg_cnt", cnt, 32'd6);
        chk("kg_err", {28'd0, err}, 32'd0);
        step();
        chk("kg_cnt_hold", cnt, 32'd6);

        // SIGN with engine failure
        mode = 3'b010; step(); mode = 3'b000;
        chk("sg_op", {30'd0, op}, 32'd2);
        chk("sg_done_cleared", {31'd0, sdone}, 32'd0);
        step();
        done = 1'b1; fail = 1'b1; step(); done = 1'b0; fail = 1'b0;
        chk("sg_done", {31'd0, sdone}, 32'd0);
        chk("sg_err", {28'd0, err}, 32'd8);
        chk("sg_busy", {31'd0, busy}, 32'd0);
        chk("sg_cnt", cnt, 32'd2);
        clr = 1'b1; step(); clr = 1'b0;
        chk("sg_clr", {28'd0, err}, 32'd0);

        // VERIFY with watchdog timeout at 16
        mode = 3'b011; step(); mode = 3'b000;
        for (int i = 0; i < 15; i++) step();
        chk("to_cnt15", cnt, 32'd15);
        step();
        chk("to_cnt16_run", {31'd0, abrt}, 32'd0);
        chk("to_cnt16", cnt, 32'd16);
        step();
        chk("to_abort", {31'd0, abrt}, 32'd1);
        chk("to_abort_busy", {31'd0, busy}, 32'd1);
        chk("to_err", {28'd0, err}, 32'd4);
        chk("to_cnt_frozen", cnt, 32'd16);
        step();
        chk("to_abort_once", {31'd0, abrt}, 32'd0);
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_cnt_final", cnt, 32'd16);
        chk("to_nodone", {31'd0, sdone}, 32'd0);
        clr = 1'b1; step(); clr = 1'b0;

        // Overrun then abort; done in the abort cycle must be ignored
        mode = 3'b001; step(); mode = 3'b000;
        step();
        mode = 3'b010; step(); mode = 3'b000;
        chk("ov_err", {28'd0, err}, 32'd2);
        chk("ov_op", {30'd0, op}, 32'd1);
        chk("ov_busy", {31'd0, busy}, 32'd1);
        mode = 3'b111; done = 1'b1; step(); mode = 3'b000; done = 1'b0;
        chk("ab_pulse", {31'd0, abrt}, 32'd1);
        chk("ab_busy", {31'd0, busy}, 32'd1);
        chk("ab_nodone", {31'd0, sdone}, 32'd0);
        chk("ab_cnt", cnt, 32'd3);
        step();
        chk("ab_once", {31'd0, abrt}, 32'd0);
        chk("ab_idle", {31'd0, busy}, 32'd0);
        chk("ab_err", {28'd0, err}, 32'd2);
        chk("ab_done_end", {31'd0, sdone}, 32'd0);
        clr = 1'b1; step(); clr = 1'b0;

        // Illegal mode and idle soft-clear
        mode = 3'b101; step(); mode = 3'b000;
        chk("il_err", {28'd0, err}, 32'd1);
        chk("il_strobes", {29'd0, start, abrt, busy}, 32'd0);
        mode = 3'b111; step(); mode = 3'b000;
        chk("ic_err", {28'd0, err}, 32'd0);
        chk("ic_strobes", {29'd0, start, abrt, busy}, 32'd0);
        mode = 3'b110; clr = 1'b1; step(); mode = 3'b000; clr = 1'b0;
        chk("set_beats_clr", {28'd0, err}, 32'd1);
        clr = 1'b1; step(); clr = 1'b0;
        done = 1'b1; step(); done = 1'b0;
        chk("idle_done_ign", {30'd0, sdone, busy}, 32'd0);

        // Done in the same cycle as the watchdog limit wins; then back-to-back command
        mode = 3'b001; step(); mode = 3'b000;
        for (int i = 0; i < 16; i++) step();
        chk("dw_cnt16", cnt, 32'd16);
        done = 1'b1; step(); done = 1'b0;
        chk("dw_done", {31'd0, sdone}, 32'd1);
        chk("dw_err", {28'd0, err}, 32'd0);
        chk("dw_cnt", cnt, 32'd17);
        chk("dw_abort", {31'd0, abrt}, 32'd0);
        mode = 3'b010; step(); mode = 3'b000;
        chk("b2b_start", {31'd0, start}, 32'd1);
        chk("b2b_op", {30'd0, op}, 32'd2);
        chk("b2b_cnt", cnt, 32'd0);
        chk("b2b_done_clr", {31'd0, sdone}, 32'd0);

        // Asynchronous reset mid-run
        step();
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_op_cnt", {op, cnt[29:0]}, 32'd0);
        chk("mr_strobes", {27'd0, start, abrt, err}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("mr_no_abort", {31'd0, abrt}, 32'd0);
        mode = 3'b001; step(); mode = 3'b000;
        chk("mr_start", {31'd0, start}, 32'd1);
        step();
        done = 1'b1; step(); done = 1'b0;
        chk("mr_done", {31'd0, sdone}, 32'd1);
        chk("mr_cnt", cnt, 32'd2);
        chk("mr_op", {30'd0, op}, 32'd1);

        // Narrow counter saturates; watchdog disabled
        mode2 = 3'b001; step(); mode2 = 3'b000;
        for (int i = 0; i < 12; i++) step();
        chk("sat_cnt", {29'd0, s_cnt}, 32'd7);
        chk("sat_busy", {31'd0, s_busy}, 32'd1);
        chk("sat_no_abort", {31'd0, s_abrt}, 32'd0);
        chk("sat_no_err", {28'd0, s_err}, 32'd0);
        done2 = 1'b1; step(); done2 = 1'b0;
        chk("sat_done", {31'd0, s_sdone}, 32'd1);
        chk("sat_cnt_end", {29'd0, s_cnt}, 32'd7);
        chk("sat_idle", {31'd0, s_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
